// File: rtl/axi_bridge_nport.sv
// axi_bridge_nport: arbitrates N_PORTS SRAM-like request ports onto one AXI3 master.
// One outstanding read per port (AXI ID = port index), one outstanding write overall,
// round-robin grant, and word-address hazard stalls between reads and the write slot.
module axi_bridge_nport #(
    parameter int N_PORTS = 2
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [N_PORTS-1:0]      sram_req,
    input  logic [N_PORTS-1:0]      sram_wr,
    input  logic [2*N_PORTS-1:0]    sram_size,
    input  logic [4*N_PORTS-1:0]    sram_wstrb,
    input  logic [32*N_PORTS-1:0]   sram_addr,
    input  logic [32*N_PORTS-1:0]   sram_wdata,
    output logic [N_PORTS-1:0]      sram_addr_ok,
    output logic [N_PORTS-1:0]      sram_data_ok,
    output logic [32*N_PORTS-1:0]   sram_rdata,
    output logic [3:0]              arid,
    output logic [31:0]             araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic [1:0]              arlock,
    output logic [3:0]              arcache,
    output logic [2:0]              arprot,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [3:0]              rid,
    input  logic [31:0]             rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [3:0]              awid,
    output logic [31:0]             awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic [1:0]              awlock,
    output logic [3:0]              awcache,
    output logic [2:0]              awprot,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [3:0]              wid,
    output logic [31:0]             wdata,
    output logic [3:0]              wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [3:0]              bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);
    localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef enum logic [1:0] {W_IDLE, W_SEND, W_WAIT_B} wstate_t;

    wstate_t             wstate;
    logic [PW-1:0]       w_owner;
    logic [PW-1:0]       rr_ptr;
    logic [N_PORTS-1:0]  rd_busy;
    logic [29:0]         rd_addr [N_PORTS];

    logic [N_PORTS-1:0]  rd_hazard, wr_hazard, rd_elig, wr_elig, elig;
    logic                grant_any;
    logic [PW-1:0]       grant_idx;
    logic                g_wr;
    logic [1:0]          g_size;
    logic [3:0]          g_wstrb;
    logic [31:0]         g_addr, g_wdata;
    logic                r_hit, b_hit, aw_done, w_done;

    // Responses carry no information the SRAM side can use.
    logic unused_resp;
    assign unused_resp = ^{rresp, rlast, bid, bresp};

    assign arlen   = 8'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign awlen   = 8'd0;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign wlast   = 1'b1;
    assign wid     = awid;

    // Hazards on word address: reads vs the live write slot, writes vs any outstanding read.
    always_comb begin
        rd_hazard = '0;
        wr_hazard = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            rd_hazard[i] = (wstate != W_IDLE) && (sram_addr[i*32+2 +: 30] == awaddr[31:2]);
            for (int j = 0; j < N_PORTS; j++) begin
                if (rd_busy[j] && (rd_addr[j] == sram_addr[i*32+2 +: 30]))
                    wr_hazard[i] = 1'b1;
            end
        end
        rd_elig = sram_req & ~sram_wr & ~rd_busy & {N_PORTS{~arvalid}} & ~rd_hazard;
        wr_elig = sram_req & sram_wr & {N_PORTS{wstate == W_IDLE}} & ~wr_hazard;
        elig    = (rd_elig | wr_elig) & {N_PORTS{~areset}};
    end

    // Round-robin pick: scan downward so the lowest offset from rr_ptr wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            if (elig[(int'(rr_ptr) + k) % N_PORTS]) begin
                grant_any = 1'b1;
                grant_idx = PW'((int'(rr_ptr) + k) % N_PORTS);
            end
        end
    end

    // Mux the granted port's request fields and raise its addr_ok.
    always_comb begin
        g_wr         = 1'b0;
        g_size       = 2'd0;
        g_wstrb      = 4'd0;
        g_addr       = 32'd0;
        g_wdata      = 32'd0;
        sram_addr_ok = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant_idx == PW'(i)) begin
                g_wr    = sram_wr[i];
                g_size  = (sram_size[i*2 +: 2] == 2'd3) ? 2'd2 : sram_size[i*2 +: 2];
                g_wstrb = sram_wstrb[i*4 +: 4];
                g_addr  = sram_addr[i*32 +: 32];
                g_wdata = sram_wdata[i*32 +: 32];
                sram_addr_ok[i] = grant_any;
            end
        end
    end

    assign r_hit   = rvalid && (rid < 4'(N_PORTS)) && rd_busy[rid[PW-1:0]];
    assign b_hit   = bvalid && (wstate == W_WAIT_B);
    assign aw_done = !awvalid || awready;
    assign w_done  = !wvalid || wready;

    // Route R data and B acknowledgements back to the owning port in the same cycle.
    always_comb begin
        sram_data_ok = '0;
        sram_rdata   = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (r_hit && rid[PW-1:0] == PW'(i)) begin
                sram_data_ok[i]       = 1'b1;
                sram_rdata[i*32 +: 32] = rdata;
            end
            if (b_hit && w_owner == PW'(i))
                sram_data_ok[i] = 1'b1;
        end
    end

    // Read side: AR register, per-port busy tracking and the round-robin pointer.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            arvalid <= 1'b0;
            arid    <= 4'd0;
            araddr  <= 32'd0;
            arsize  <= 3'd0;
            rd_busy <= '0;
            rr_ptr  <= '0;
            rready  <= 1'b0;
            bready  <= 1'b0;
            for (int i = 0; i < N_PORTS; i++) rd_addr[i] <= 30'd0;
        end else begin
            rready <= 1'b1;
            bready <= 1'b1;
            if (arvalid && arready) arvalid <= 1'b0;
            for (int i = 0; i < N_PORTS; i++) begin
                if (r_hit && rid[PW-1:0] == PW'(i)) rd_busy[i] <= 1'b0;
            end
            if (grant_any) begin
                rr_ptr <= (grant_idx == PW'(N_PORTS - 1)) ? '0 : grant_idx + 1'b1;
                if (!g_wr) begin
                    arvalid              <= 1'b1;
                    arid                 <= 4'(grant_idx);
                    araddr               <= g_addr;
                    arsize               <= {1'b0, g_size};
                    rd_busy[grant_idx]   <= 1'b1;
                    rd_addr[grant_idx]   <= g_addr[31:2];
                end
            end
        end
    end

    // Write slot FSM: AW and W handshakes complete independently, then wait for B.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wstate  <= W_IDLE;
            w_owner <= '0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            awid    <= 4'd0;
            awaddr  <= 32'd0;
            awsize  <= 3'd0;
            wdata   <= 32'd0;
            wstrb   <= 4'd0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (grant_any && g_wr) begin
                        wstate  <= W_SEND;
                        w_owner <= grant_idx;
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                        awid    <= 4'(grant_idx);
                        awaddr  <= g_addr;
                        awsize  <= {1'b0, g_size};
                        wdata   <= g_wdata;
                        wstrb   <= g_wstrb;
                    end
                end
                W_SEND: begin
                    if (awready) awvalid <= 1'b0;
                    if (wready)  wvalid  <= 1'b0;
                    if (aw_done && w_done) wstate <= W_WAIT_B;
                end
                W_WAIT_B: begin
                    if (bvalid) wstate <= W_IDLE;
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_bridge_nport.sv
// Scenario bench for axi_bridge_nport (N_PORTS=2). AXI slave responses are driven
// cycle by cycle from each scenario; a scoreboard of expected data_ok events is
// filled at grant time and drained by a negedge monitor.
module tb_axi_bridge_nport;
    localparam int N = 2;

    logic            aclk = 1'b0;
    logic            areset;
    logic [N-1:0]    sram_req, sram_wr;
    logic [2*N-1:0]  sram_size;
    logic [4*N-1:0]  sram_wstrb;
    logic [32*N-1:0] sram_addr, sram_wdata;
    logic [N-1:0]    sram_addr_ok, sram_data_ok;
    logic [32*N-1:0] sram_rdata;
    logic [3:0]      arid, awid, wid, rid, bid;
    logic [31:0]     araddr, awaddr, wdata, rdata;
    logic [7:0]      arlen, awlen;
    logic [2:0]      arsize, awsize, arprot, awprot;
    logic [1:0]      arburst, arlock, awburst, awlock, rresp, bresp;
    logic [3:0]      arcache, awcache, wstrb;
    logic            arvalid, arready, rlast, rvalid, rready;
    logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    typedef struct {
        int          port;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;
    int mon_found;

    axi_bridge_nport #(.N_PORTS(N)) dut (
        .aclk(aclk), .areset(areset),
        .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size),
        .sram_wstrb(sram_wstrb), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 aclk = ~aclk;

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Scoreboard drain: every data_ok must match the oldest expectation for that port.
    always @(negedge aclk) begin
        if (areset === 1'b0) begin
            for (int p = 0; p < N; p++) begin
                if (sram_data_ok[p]) begin
                    mon_found = -1;
                    for (int k = 0; k < sb_q.size(); k++)
                        if (sb_q[k].port == p && mon_found < 0) mon_found = k;
                    checks++;
                    if (mon_found < 0) begin
                        errors++;
                        $display("FAIL sb_unexpected port=%0d actual data_ok=1 required data_ok=0", p);
                    end else begin
                        if (sram_rdata[p*32 +: 32] !== sb_q[mon_found].data) begin
                            errors++;
                            $display("FAIL sb_rdata port=%0d actual=%h required=%h", p,
                                     sram_rdata[p*32 +: 32], sb_q[mon_found].data);
                        end
                        sb_q.delete(mon_found);
                    end
                end else begin
                    checks++;
                    if (sram_rdata[p*32 +: 32] !== 32'd0) begin
                        errors++;
                        $display("FAIL rdata_idle port=%0d actual=%h required=0", p, sram_rdata[p*32 +: 32]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_inputs();
        sram_req = '0; sram_wr = '0; sram_size = '0; sram_wstrb = '0;
        sram_addr = '0; sram_wdata = '0;
        arready = 0; awready = 0; wready = 0;
        rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
        bid = 0; bresp = 0; bvalid = 0;
    endtask

    task automatic set_req(input int p, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] st, input logic [1:0] sz);
        sram_req[p] = 1'b1;
        sram_wr[p] = wr;
        sram_addr[p*32 +: 32] = a;
        sram_wdata[p*32 +: 32] = wd;
        sram_wstrb[p*4 +: 4] = st;
        sram_size[p*2 +: 2] = sz;
    endtask

    task automatic clr_req(input int p);
        sram_req[p] = 1'b0;
        sram_wr[p] = 1'b0;
    endtask

    task automatic push_exp(input int p, input logic [31:0] d);
        exp_t e;
        e.port = p;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic apply_reset();
        areset = 1'b1;
        clear_inputs();
        tick(); tick();
        areset = 1'b0;
        tick();
        sb_q.delete();
    endtask

    task automatic check_sb_empty(input string name);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_sb_pending actual=%0d required=0", name, sb_q.size());
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        clear_inputs();
        sram_req = 2'b11;
        tick(); tick();
        @(negedge aclk);
        checks++; if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin errors++;
            $display("FAIL reset_valids actual=%b required=00000", {arvalid, awvalid, wvalid, rready, bready}); end
        checks++; if (sram_addr_ok !== 2'b00) begin errors++;
            $display("FAIL reset_addr_ok actual=%b required=00", sram_addr_ok); end
        checks++; if (sram_data_ok !== 2'b00 || sram_rdata !== '0) begin errors++;
            $display("FAIL reset_data_ok actual=%b/%h required=00/0", sram_data_ok, sram_rdata); end
        tick();
        sram_req = 2'b00;
        areset = 1'b0;
        @(negedge aclk);
        checks++; if (rready !== 1'b0) begin errors++;
            $display("FAIL rready_release actual=%b required=0", rready); end
        tick();
        @(negedge aclk);
        checks++; if (rready !== 1'b1 || bready !== 1'b1) begin errors++;
            $display("FAIL ready_after actual=%b%b required=11", rready, bready); end
        checks++; if ({arlen, awlen, arburst, awburst, wlast} !== {8'd0, 8'd0, 2'b01, 2'b01, 1'b1}) begin errors++;
            $display("FAIL constants actual=%h required=%h", {arlen, awlen, arburst, awburst, wlast},
                     {8'd0, 8'd0, 2'b01, 2'b01, 1'b1}); end
    endtask

    task automatic test_single_read();
        apply_reset();
        set_req(0, 1'b0, 32'h1C00_0000, 32'd0, 4'd0, 2'd2);
        @(negedge aclk);
        checks++; if (sram_addr_ok !== 2'b01) begin errors++;
            $display("FAIL rd1_addr_ok actual=%b required=01", sram_addr_ok); end
        push_exp(0, 32'hDEAD_BEEF);
        tick();
        clr_req(0);
        arready = 1'b1;
        @(negedge aclk);
        checks++; if ({arvalid, arid, araddr, arsize} !== {1'b1, 4'd0, 32'h1C00_0000, 3'd2}) begin errors++;
            $display("FAIL rd1_ar actual=%b/%h/%h/%h required=1/0/1c000000/2", arvalid, arid, araddr, arsize); end
        checks++; if (sram_data_ok !== 2'b00) begin errors++;
            $display("FAIL rd1_early_data_ok actual=%b required=00", sram_data_ok); end
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rid = 4'd0; rdata = 32'hDEAD_BEEF;
        @(negedge aclk);
        checks++; if (arvalid !== 1'b0) begin errors++;
            $display("FAIL rd1_ar_drop actual=%b required=0", arvalid); end
        checks++; if (sram_data_ok !== 2'b01) begin errors++;
            $display("FAIL rd1_data_ok actual=%b required=01", sram_data_ok); end
        tick();
        rvalid = 1'b0;
        @(negedge aclk);
        check_sb_empty("rd1");
    endtask

    task automatic test_rr_reads();
        logic [1:0] exp_ok [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [31:0] a0 [2] = '{32'h1000, 32'h1004};
        logic [31:0] a1 [2] = '{32'h2000, 32'h2004};
        apply_reset();
        for (int r = 0; r < 2; r++) begin
            set_req(0, 1'b0, a0[r], 32'd0, 4'd0, 2'd2);
            set_req(1, 1'b0, a1[r], 32'd0, 4'd0, 2'd2);
            @(negedge aclk);
            checks++; if (sram_addr_ok !== exp_ok[2*r]) begin errors++;
                $display("FAIL rr_grant%0d actual=%b required=%b", 2*r, sram_addr_ok, exp_ok[2*r]); end
            push_exp(0, mem_word(a0[r]));
            tick();
            arready = 1'b1;
            @(negedge aclk);
            checks++; if (sram_addr_ok !== 2'b00 || arid !== 4'd0 || araddr !== a0[r]) begin errors++;
                $display("FAIL rr_ar0 actual=%b/%h/%h required=00/0/%h", sram_addr_ok, arid, araddr, a0[r]); end
            tick();
            arready = 1'b0;
            @(negedge aclk);
            checks++; if (sram_addr_ok !== exp_ok[2*r+1]) begin errors++;
                $display("FAIL rr_grant%0d actual=%b required=%b", 2*r+1, sram_addr_ok, exp_ok[2*r+1]); end
            push_exp(1, mem_word(a1[r]));
            tick();
            arready = 1'b1;
            @(negedge aclk);
            checks++; if (sram_addr_ok !== 2'b00 || arid !== 4'd1 || araddr !== a1[r]) begin errors++;
                $display("FAIL rr_ar1 actual=%b/%h/%h required=00/1/%h", sram_addr_ok, arid, araddr, a1[r]); end
            tick();
            arready = 1'b0;
            clr_req(0); clr_req(1);
            // First round answers port 1 first (out of order), second round in order.
            rvalid = 1'b1; rid = (r == 0) ? 4'd1 : 4'd0;
            rdata = (r == 0) ? mem_word(a1[r]) : mem_word(a0[r]);
            @(negedge aclk);
            checks++; if (sram_data_ok !== ((r == 0) ? 2'b10 : 2'b01)) begin errors++;
                $display("FAIL rr_resp_a%0d actual=%b required=%b", r, sram_data_ok, (r == 0) ? 2'b10 : 2'b01); end
            tick();
            rid = (r == 0) ? 4'd0 : 4'd1;
            rdata = (r == 0) ? mem_word(a0[r]) : mem_word(a1[r]);
            @(negedge aclk);
            checks++; if (sram_data_ok !== ((r == 0) ? 2'b01 : 2'b10)) begin errors++;
                $display("FAIL rr_resp_b%0d actual=%b required=%b", r, sram_data_ok, (r == 0) ? 2'b01 : 2'b10); end
            tick();
            rvalid = 1'b0;
        end
        rvalid = 1'b1; rid = 4'd0; rdata = 32'h1234_5678;
        @(negedge aclk);
        checks++; if (sram_data_ok !== 2'b00) begin errors++;
            $display("FAIL rr_idle_rid actual=%b required=00", sram_data_ok); end
        tick();
        rvalid = 1'b0;
        check_sb_empty("rr");
    endtask

    task automatic test_write_delayed_aw();
        apply_reset();
        set_req(1, 1'b1, 32'h100, 32'hCAFE_F00D, 4'hF, 2'd2);
        @(negedge aclk);
        checks++; if (sram_addr_ok !== 2'b10) begin errors++;
            $display("FAIL wr_addr_ok actual=%b required=10", sram_addr_ok); end
        push_exp(1, 32'd0);
        tick();
        clr_req(1);
        wready = 1'b1;
        @(negedge aclk);
        checks++; if ({awvalid, wvalid, awid, wid, awaddr, wdata, wstrb, awsize} !==
                      {1'b1, 1'b1, 4'd1, 4'd1, 32'h100, 32'hCAFE_F00D, 4'hF, 3'd2}) begin errors++;
            $display("FAIL wr_aw_w actual=%b%b/%h/%h/%h/%h/%h/%h required=11/1/1/100/cafef00d/f/2",
                     awvalid, wvalid, awid, wid, awaddr, wdata, wstrb, awsize); end
        tick();
        wready = 1'b0;
        @(negedge aclk);
        checks++; if ({awvalid, wvalid} !== 2'b10) begin errors++;
            $display("FAIL wr_t2 actual=%b required=10", {awvalid, wvalid}); end
        tick();
        @(negedge aclk);
        checks++; if ({awvalid, wvalid} !== 2'b10) begin errors++;
            $display("FAIL wr_t3 actual=%b required=10", {awvalid, wvalid}); end
        awready = 1'b1;
        tick();
        awready = 1'b0;
        bvalid = 1'b1; bid = 4'd1;
        @(negedge aclk);
        checks++; if ({awvalid, wvalid} !== 2'b00) begin errors++;
            $display("FAIL wr_t4 actual=%b required=00", {awvalid, wvalid}); end
        checks++; if (sram_data_ok !== 2'b10) begin errors++;
            $display("FAIL wr_data_ok actual=%b required=10", sram_data_ok); end
        tick();
        bvalid = 1'b0;
        @(negedge aclk);
        check_sb_empty("wr");
    endtask

    task automatic test_raw_hazard();
        apply_reset();
        set_req(1, 1'b1, 32'h100, 32'h0BAD_F00D, 4'hF, 2'd2);
        @(negedge aclk);
        push_exp(1, 32'd0);
        tick();
        clr_req(1);
        awready = 1'b1; wready = 1'b1;
        tick();
        awready = 1'b0; wready = 1'b0;
        set_req(0, 1'b0, 32'h102, 32'd0, 4'd0, 2'd1);
        for (int c = 0; c < 2; c++) begin
            @(negedge aclk);
            checks++; if (sram_addr_ok !== 2'b00) begin errors++;
                $display("FAIL raw_stall%0d actual=%b required=00", c, sram_addr_ok); end
            tick();
        end
        bvalid = 1'b1; bid = 4'd1;
        @(negedge aclk);
        checks++; if (sram_addr_ok !== 2'b00 || sram_data_ok !== 2'b10) begin errors++;
            $display("FAIL raw_bvalid actual=%b/%b required=00/10", sram_addr_ok, sram_data_ok); end
        tick();
        bvalid = 1'b0;
        @(negedge aclk);
        checks++; if (sram_addr_ok !== 2'b01) begin errors++;
            $display("FAIL raw_release actual=%b required=01", sram_addr_ok); end
        push_exp(0, mem_word(32'h102));
        tick();
        clr_req(0);
        arready = 1'b1;
        @(negedge aclk);
        checks++; if (araddr !== 32'h102 || arsize !== 3'd1) begin errors++;
            $display("FAIL raw_ar actual=%h/%h required=102/1", araddr, arsize); end
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rid = 4'd0; rdata = mem_word(32'h102);
        tick();
        rvalid = 1'b0;
        @(negedge aclk);
        check_sb_empty("raw");
    endtask

    task automatic test_war_hazard();
        apply_reset();
        set_req(0, 1'b0, 32'h200, 32'd0, 4'd0, 2'd2);
        @(negedge aclk);
        push_exp(0, mem_word(32'h200));
        tick();
        clr_req(0);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        set_req(1, 1'b1, 32'h200, 32'h1111_2222, 4'h3, 2'd2);
        for (int c = 0; c < 2; c++) begin
            @(negedge aclk);
            checks++; if (sram_addr_ok !== 2'b00) begin errors++;
                $display("FAIL war_stall%0d actual=%b required=00", c, sram_addr_ok); end
            tick();
        end
        rvalid = 1'b1; rid = 4'd0; rdata = mem_word(32'h200);
        @(negedge aclk);
        checks++; if (sram_addr_ok !== 2'b00) begin errors++;
            $display("FAIL war_rvalid actual=%b required=00", sram_addr_ok); end
        tick();
        rvalid = 1'b0;
        @(negedge aclk);
        checks++; if (sram_addr_ok !== 2'b10) begin errors++;
            $display("FAIL war_release actual=%b required=10", sram_addr_ok); end
        push_exp(1, 32'd0);
        tick();
        clr_req(1);
        awready = 1'b1; wready = 1'b1;
        tick();
        awready = 1'b0; wready = 1'b0;
        bvalid = 1'b1; bid = 4'd1;
        tick();
        bvalid = 1'b0;
        set_req(0, 1'b0, 32'h200, 32'd0, 4'd0, 2'd2);
        @(negedge aclk);
        push_exp(0, mem_word(32'h200));
        tick();
        clr_req(0);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        set_req(1, 1'b1, 32'h204, 32'h3333_4444, 4'hF, 2'd2);
        @(negedge aclk);
        checks++; if (sram_addr_ok !== 2'b10) begin errors++;
            $display("FAIL war_other_word actual=%b required=10", sram_addr_ok); end
        push_exp(1, 32'd0);
        tick();
        clr_req(1);
        awready = 1'b1; wready = 1'b1;
        tick();
        awready = 1'b0; wready = 1'b0;
        bvalid = 1'b1; bid = 4'd1;
        rvalid = 1'b1; rid = 4'd0; rdata = mem_word(32'h200);
        @(negedge aclk);
        checks++; if (sram_data_ok !== 2'b11) begin errors++;
            $display("FAIL war_dual_data_ok actual=%b required=11", sram_data_ok); end
        tick();
        bvalid = 1'b0; rvalid = 1'b0;
        @(negedge aclk);
        check_sb_empty("war");
    endtask

    task automatic test_reset_mid();
        apply_reset();
        set_req(0, 1'b0, 32'h300, 32'd0, 4'd0, 2'd2);
        @(negedge aclk);
        checks++; if (sram_addr_ok !== 2'b01) begin errors++;
            $display("FAIL rst_rd_grant actual=%b required=01", sram_addr_ok); end
        tick();
        clr_req(0);
        set_req(1, 1'b1, 32'h400, 32'h5555_6666, 4'hF, 2'd2);
        @(negedge aclk);
        checks++; if (sram_addr_ok !== 2'b10 || arvalid !== 1'b1) begin errors++;
            $display("FAIL rst_wr_grant actual=%b/%b required=10/1", sram_addr_ok, arvalid); end
        tick();
        clear_inputs();
        areset = 1'b1;
        #1;
        checks++; if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin errors++;
            $display("FAIL rst_mid_valids actual=%b required=00000", {arvalid, awvalid, wvalid, rready, bready}); end
        tick(); tick();
        areset = 1'b0;
        tick();
        rvalid = 1'b1; rid = 4'd0; rdata = 32'hBAD0_BAD0;
        bvalid = 1'b1; bid = 4'd1;
        @(negedge aclk);
        checks++; if (sram_data_ok !== 2'b00) begin errors++;
            $display("FAIL rst_stale_resp actual=%b required=00", sram_data_ok); end
        tick();
        rvalid = 1'b0; bvalid = 1'b0;
        set_req(0, 1'b0, 32'h500, 32'd0, 4'd0, 2'd2);
        @(negedge aclk);
        checks++; if (sram_addr_ok !== 2'b01) begin errors++;
            $display("FAIL rst_fresh_grant actual=%b required=01", sram_addr_ok); end
        push_exp(0, mem_word(32'h500));
        tick();
        clr_req(0);
        arready = 1'b1;
        @(negedge aclk);
        checks++; if (arvalid !== 1'b1 || araddr !== 32'h500) begin errors++;
            $display("FAIL rst_fresh_ar actual=%b/%h required=1/500", arvalid, araddr); end
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rid = 4'd0; rdata = mem_word(32'h500);
        @(negedge aclk);
        checks++; if (sram_data_ok !== 2'b01) begin errors++;
            $display("FAIL rst_fresh_data_ok actual=%b required=01", sram_data_ok); end
        tick();
        rvalid = 1'b0;
        @(negedge aclk);
        check_sb_empty("rst");
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_rr_reads();
        test_write_delayed_aw();
        test_raw_hazard();
        test_war_hazard();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
